// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants, state encoding and helpers for the IF stage
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction-memory request/grant/read-data bus
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// rtl/inst_fetch_if_id_reg.sv - IF/ID pipeline register with bubble and hold behaviour
module inst_fetch_if_id_reg
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_stall_if,
  input  logic        i_stall_id,
  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  // pc is left alone on bubbles so ID still sees the last real fetch address
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0;
      r_valid <= 1'b0;
    end else if (!i_stall_if) begin
      if (i_valid) begin
        r_inst  <= i_inst;
        r_pc    <= i_pc;
        r_valid <= 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end
    end else if (!i_stall_id) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: PC, single-outstanding imem fetch, delay-slot redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [5:0]   stall,
  input  logic         jump,
  input  logic [31:0]  jumppc,
  inst_fetch_if.master imem,
  output logic [31:0]  inst_o,
  output logic [31:0]  pc_o,
  output logic         inst_valid_o,
  output logic         stallreq_o
);

  if_state_e   r_state, w_next_state;
  logic [31:0] r_pc, r_npc, r_req_pc, r_buf_inst, r_buf_pc, r_redirect_pc;
  logic        r_npc_valid, r_redirect_pending, r_stallreq;
  logic        w_req, w_grant, w_deliver, w_capture, w_unused;
  logic [31:0] w_cur_pc, w_next_pc, w_target, w_del_inst, w_del_pc;

  assign w_unused  = ^stall[5:3];

  // a PC update deferred by stall[0] is bypassed onto the bus the moment stall drops
  assign w_cur_pc  = r_npc_valid ? r_npc : r_pc;
  assign w_target  = r_redirect_pending ? r_redirect_pc : jumppc;
  assign w_next_pc = (r_redirect_pending || jump) ? align_word(w_target) : r_pc + 32'd4;
  assign w_grant   = w_req & imem.imem_gnt;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_cur_pc;
  assign stallreq_o     = r_stallreq;

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_deliver    = 1'b0;
    w_capture    = 1'b0;
    w_del_inst   = imem.imem_rdata;
    w_del_pc     = r_req_pc;
    case (r_state)
      IF_IDLE: w_next_state = IF_REQ;
      IF_REQ: begin
        w_req = ~stall[STALL_PC];
        if (w_req && imem.imem_gnt) w_next_state = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem.imem_rvalid) begin
          if (stall[STALL_IF]) begin
            w_capture    = 1'b1;
            w_next_state = IF_HOLD;
          end else begin
            w_deliver    = 1'b1;
            w_next_state = IF_REQ;
          end
        end
      end
      IF_HOLD: begin
        if (!stall[STALL_IF]) begin
          w_deliver    = 1'b1;
          w_del_inst   = r_buf_inst;
          w_del_pc     = r_buf_pc;
          w_next_state = IF_REQ;
        end
      end
      default: w_next_state = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state            <= IF_IDLE;
      r_pc               <= RESET_PC;
      r_npc              <= RESET_PC;
      r_npc_valid        <= 1'b0;
      r_req_pc           <= 32'h0;
      r_buf_inst         <= NOP_INST;
      r_buf_pc           <= 32'h0;
      r_redirect_pending <= 1'b0;
      r_redirect_pc      <= 32'h0;
      r_stallreq         <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_stallreq <= (r_state == IF_REQ) || (r_state == IF_WAIT);
      if (w_grant) r_req_pc <= w_cur_pc;

      if (w_capture) begin
        r_buf_inst <= imem.imem_rdata;
        r_buf_pc   <= r_req_pc;
      end else if (w_deliver && (r_state == IF_HOLD)) begin
        r_buf_inst <= NOP_INST;
        r_buf_pc   <= 32'h0;
      end

      // delivery of the delay slot consumes the redirect; a second jump meanwhile is dropped
      if (w_deliver) begin
        r_redirect_pending <= 1'b0;
      end else if (jump && !r_redirect_pending) begin
        r_redirect_pending <= 1'b1;
        r_redirect_pc      <= jumppc;
      end

      if (w_deliver) begin
        if (stall[STALL_PC]) begin
          r_npc       <= w_next_pc;
          r_npc_valid <= 1'b1;
        end else begin
          r_pc <= w_next_pc;
        end
      end else if (r_npc_valid && !stall[STALL_PC]) begin
        r_pc        <= r_npc;
        r_npc_valid <= 1'b0;
      end
    end
  end

  inst_fetch_if_id_reg u_if_id (
    .clk        (clk),
    .rstn       (rstn),
    .i_stall_if (stall[STALL_IF]),
    .i_stall_id (stall[STALL_ID]),
    .i_valid    (w_deliver),
    .i_inst     (w_del_inst),
    .i_pc       (w_del_pc),
    .o_inst     (inst_o),
    .o_pc       (pc_o),
    .o_valid    (inst_valid_o)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [5:0]  stall;
  logic        jump;
  logic [31:0] jumppc;
  logic [31:0] inst_o, pc_o;
  logic        inst_valid_o, stallreq_o;
  int          n_tests = 0;
  int          n_fail  = 0;

  inst_fetch_if imem_bus ();

  inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .stall        (stall),
    .jump         (jump),
    .jumppc       (jumppc),
    .imem         (imem_bus),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  wire        req  = imem_bus.imem_req;
  wire [31:0] addr = imem_bus.imem_addr;

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] s, input logic g, input logic rv, input logic [31:0] rd);
    stall = s;
    imem_bus.imem_gnt    = g;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    jump = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    jumppc = 32'h0;
    clk_cycle();
    rstn = 1'b0;
    clk_cycle();
  endtask

  // one granted fetch: REQ cycle with gnt, rv_delay empty WAIT cycles, then rvalid
  task automatic fetch_one(input logic [31:0] rd, input int rv_delay, input logic jmp,
                           input logic [31:0] jpc, output logic [31:0] addr_seen);
    drive(6'b0, 1'b1, 1'b0, 32'h0);
    #1;
    addr_seen = addr;
    clk_cycle();
    for (int i = 0; i <= rv_delay; i++) begin
      drive(6'b0, 1'b0, (i == rv_delay), rd);
      jump   = jmp && (i == 0);
      jumppc = jpc;
      clk_cycle();
    end
    drive(6'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    jumppc = 32'h0;
    clk_cycle();
    clk_cycle();
    n_tests++;
    if ({req, addr} !== {1'b0, 32'hBFC0_0000}) begin
      n_fail++; $display("FAIL reset_bus: req=%0b addr=%h, want req=0 addr=bfc00000", req, addr);
    end
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o, stallreq_o} !== 66'h0) begin
      n_fail++; $display("FAIL reset_outputs: inst=%h pc=%h v=%0b sr=%0b, want all 0", inst_o, pc_o, inst_valid_o, stallreq_o);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (req !== 1'b0) begin n_fail++; $display("FAIL idle_req: req=%0b, want 0", req); end
    clk_cycle();
    n_tests++;
    if ({req, addr, stallreq_o} !== {1'b1, 32'hBFC0_0000, 1'b0}) begin
      n_fail++; $display("FAIL first_req: req=%0b addr=%h sr=%0b, want 1 bfc00000 0", req, addr, stallreq_o);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_inst [3];
    exp_pc   = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    exp_inst = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      fetch_one(exp_inst[k], 0, 1'b0, 32'h0, a);
      #1;
      n_tests++;
      if (a !== exp_pc[k]) begin n_fail++; $display("FAIL seq_addr%0d: addr=%h, want %h", k, a, exp_pc[k]); end
      n_tests++;
      if ({inst_o, pc_o, inst_valid_o, stallreq_o} !== {exp_inst[k], exp_pc[k], 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL seq_ifid%0d: inst=%h pc=%h v=%0b sr=%0b, want %h %h 1 1", k, inst_o, pc_o, inst_valid_o, stallreq_o, exp_inst[k], exp_pc[k]);
      end
    end
    clk_cycle();
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o, req, addr} !== {32'h0, 32'hBFC0_0008, 1'b0, 1'b1, 32'hBFC0_000C}) begin
      n_fail++; $display("FAIL seq_nop: inst=%h pc=%h v=%0b req=%0b addr=%h, want 0 bfc00008 0 1 bfc0000c", inst_o, pc_o, inst_valid_o, req, addr);
    end
  endtask

  task automatic test_jump();
    logic [31:0] a;
    do_reset();
    fetch_one(32'hA000_0000, 0, 1'b0, 32'h0, a);
    fetch_one(32'hA000_0004, 0, 1'b0, 32'h0, a);
    fetch_one(32'hA000_0008, 1, 1'b1, 32'h8000_1000, a);
    #1;
    n_tests++;
    if ({a, inst_o, pc_o, inst_valid_o} !== {32'hBFC0_0008, 32'hA000_0008, 32'hBFC0_0008, 1'b1}) begin
      n_fail++; $display("FAIL jump_delay_slot: addr=%h inst=%h pc=%h v=%0b, want bfc00008 a0000008 bfc00008 1", a, inst_o, pc_o, inst_valid_o);
    end
    n_tests++;
    if ({req, addr} !== {1'b1, 32'h8000_1000}) begin
      n_fail++; $display("FAIL jump_target: req=%0b addr=%h, want 1 80001000", req, addr);
    end
    fetch_one(32'hA100_1000, 0, 1'b0, 32'h0, a);
    fetch_one(32'hA100_1004, 0, 1'b1, 32'h8000_1003, a);
    #1;
    n_tests++;
    if ({a, pc_o, addr} !== {32'h8000_1004, 32'h8000_1004, 32'h8000_1000}) begin
      n_fail++; $display("FAIL jump_same_cycle: slot=%h pc=%h next=%h, want 80001004 80001004 80001000", a, pc_o, addr);
    end
    fetch_one(32'hA100_1000, 0, 1'b0, 32'h0, a);
    #1;
    n_tests++;
    if (addr !== 32'h8000_1004) begin
      n_fail++; $display("FAIL jump_consumed: addr=%h, want 80001004", addr);
    end
  endtask

  task automatic test_hold();
    logic [31:0] a;
    do_reset();
    fetch_one(32'hAAAA_0001, 0, 1'b0, 32'h0, a);
    drive(6'b000110, 1'b1, 1'b0, 32'h0);
    clk_cycle();
    drive(6'b000110, 1'b0, 1'b1, 32'hBBBB_0002);
    #1;
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o} !== {32'hAAAA_0001, 32'hBFC0_0000, 1'b1}) begin
      n_fail++; $display("FAIL hold_frozen1: inst=%h pc=%h v=%0b, want aaaa0001 bfc00000 1", inst_o, pc_o, inst_valid_o);
    end
    clk_cycle();
    drive(6'b000110, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({req, inst_o, inst_valid_o, stallreq_o} !== {1'b0, 32'hAAAA_0001, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL hold_frozen2: req=%0b inst=%h v=%0b sr=%0b, want 0 aaaa0001 1 1", req, inst_o, inst_valid_o, stallreq_o);
    end
    clk_cycle();
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({req, stallreq_o, inst_o} !== {1'b0, 1'b0, 32'hAAAA_0001}) begin
      n_fail++; $display("FAIL hold_release_cycle: req=%0b sr=%0b inst=%h, want 0 0 aaaa0001", req, stallreq_o, inst_o);
    end
    clk_cycle();
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o, req, addr} !== {32'hBBBB_0002, 32'hBFC0_0004, 1'b1, 1'b1, 32'hBFC0_0008}) begin
      n_fail++; $display("FAIL hold_release: inst=%h pc=%h v=%0b req=%0b addr=%h, want bbbb0002 bfc00004 1 1 bfc00008", inst_o, pc_o, inst_valid_o, req, addr);
    end
  endtask

  task automatic test_bubble();
    logic [31:0] a;
    do_reset();
    fetch_one(32'hCCCC_0001, 0, 1'b0, 32'h0, a);
    drive(6'b000010, 1'b1, 1'b0, 32'h0);
    clk_cycle();
    drive(6'b000010, 1'b0, 1'b1, 32'hDDDD_0002);
    #1;
    n_tests++;
    if ({inst_o, inst_valid_o} !== {32'h0, 1'b0}) begin
      n_fail++; $display("FAIL bubble1: inst=%h v=%0b, want 0 0", inst_o, inst_valid_o);
    end
    clk_cycle();
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({inst_o, inst_valid_o, req} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bubble2: inst=%h v=%0b req=%0b, want 0 0 0", inst_o, inst_valid_o, req);
    end
    clk_cycle();
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o} !== {32'hDDDD_0002, 32'hBFC0_0004, 1'b1}) begin
      n_fail++; $display("FAIL bubble_deliver: inst=%h pc=%h v=%0b, want dddd0002 bfc00004 1", inst_o, pc_o, inst_valid_o);
    end
    fetch_one(32'hEEEE_0003, 0, 1'b0, 32'h0, a);
    #1;
    n_tests++;
    if ({a, pc_o} !== {32'hBFC0_0008, 32'hBFC0_0008}) begin
      n_fail++; $display("FAIL bubble_pcseq: addr=%h pc=%h, want bfc00008 bfc00008", a, pc_o);
    end
  endtask

  task automatic test_gnt_delay();
    logic [5:0]  st [5];
    logic        gn [5];
    logic        exp_req [5];
    st      = '{6'd1, 6'd0, 6'd1, 6'd0, 6'd0};
    gn      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_req = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(st[k], gn[k], 1'b0, 32'h0);
      #1;
      n_tests++;
      if ({req, addr} !== {exp_req[k], 32'hBFC0_0000} || (k > 0 && stallreq_o !== 1'b1)) begin
        n_fail++; $display("FAIL gnt_delay%0d: req=%0b addr=%h sr=%0b, want %0b bfc00000 sr=1", k, req, addr, stallreq_o, exp_req[k]);
      end
      clk_cycle();
    end
    drive(6'd1, 1'b0, 1'b1, 32'hF00D_0000);
    #1;
    n_tests++;
    if ({req, stallreq_o} !== 2'b01) begin
      n_fail++; $display("FAIL gnt_wait: req=%0b sr=%0b, want 0 1", req, stallreq_o);
    end
    clk_cycle();
    drive(6'd1, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({inst_o, pc_o, inst_valid_o, req} !== {32'hF00D_0000, 32'hBFC0_0000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL gnt_deliver: inst=%h pc=%h v=%0b req=%0b, want f00d0000 bfc00000 1 0", inst_o, pc_o, inst_valid_o, req);
    end
    clk_cycle();
    drive(6'd0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({req, addr} !== {1'b1, 32'hBFC0_0004}) begin
      n_fail++; $display("FAIL pc_deferred: req=%0b addr=%h, want 1 bfc00004", req, addr);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a;
    do_reset();
    fetch_one(32'h1234_5678, 0, 1'b0, 32'h0, a);
    drive(6'b0, 1'b1, 1'b0, 32'h0);
    clk_cycle();
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    rstn = 1'b1;
    #1;
    n_tests++;
    if ({req, addr, inst_o, pc_o, inst_valid_o, stallreq_o} !== {1'b0, 32'hBFC0_0000, 66'h0}) begin
      n_fail++; $display("FAIL mid_reset: req=%0b addr=%h inst=%h pc=%h v=%0b sr=%0b, want 0 bfc00000 0 0 0 0", req, addr, inst_o, pc_o, inst_valid_o, stallreq_o);
    end
    clk_cycle();
    rstn = 1'b0;
    drive(6'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    clk_cycle();
    drive(6'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    n_tests++;
    if ({req, addr} !== {1'b1, 32'hBFC0_0000}) begin
      n_fail++; $display("FAIL mid_restart: req=%0b addr=%h, want 1 bfc00000", req, addr);
    end
    clk_cycle();
    drive(6'b0, 1'b0, 1'b0, 32'h0);
    #1;
    n_tests++;
    if ({inst_o, inst_valid_o} !== {32'h0, 1'b0}) begin
      n_fail++; $display("FAIL late_rvalid: inst=%h v=%0b, want 0 0", inst_o, inst_valid_o);
    end
    fetch_one(32'h0BAD_F00D, 0, 1'b0, 32'h0, a);
    #1;
    n_tests++;
    if ({a, inst_o, pc_o} !== {32'hBFC0_0000, 32'h0BAD_F00D, 32'hBFC0_0000}) begin
      n_fail++; $display("FAIL mid_refetch: addr=%h inst=%h pc=%h, want bfc00000 0badf00d bfc00000", a, inst_o, pc_o);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_hold();
    test_bubble();
    test_gnt_delay();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
